mem_port_arbiter: RTL and testbench

//  Shares the single main-memory line port between the I-cache and D-cache refill/write-back engines

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_fairness_ctr.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter:
// FSM states, owner encoding and width defaults.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 28;
  localparam int DEF_LINE_W = 128;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D,
    RELEASE
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_e;

endpackage

// File: rtl/mem_arb_fairness_ctr.sv
// Counts consecutive D grants taken while I waits and
// raises force_i once the run limit is reached.
module mem_arb_fairness_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_RUN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d_grant,
  input  logic i_grant,
  input  logic i_pending,
  output logic force_i
);

  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_D_RUN);

  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;

  always_comb begin
    run_cnt_d = run_cnt_q;
    if (i_grant) begin
      run_cnt_d = '0;
    end else if (d_grant) begin
      if (!i_pending) begin
        run_cnt_d = '0;
      end else if (run_cnt_q != RUN_MAX) begin
        run_cnt_d = run_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
    end
  end

  assign force_i = (run_cnt_q == RUN_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the memory line port between the I-cache and
// D-cache engines; D has priority, bounded by a fairness run.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int LINE_W    = DEF_LINE_W,
  parameter int MAX_D_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              grant_i,
  output logic              grant_d
);

  state_e state_q, state_d;
  owner_e owner_q, owner_d;

  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

  logic d_req;
  logic do_gnt_i;
  logic do_gnt_d;
  logic force_i;

  assign d_req = d_mem_read | d_mem_write;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    do_gnt_i    = 1'b0;
    do_gnt_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (d_req && !(i_mem_read && force_i)) begin
          do_gnt_d    = 1'b1;
          state_d     = GNT_D;
          owner_d     = OWN_D;
          // write-back goes first; the refill re-arbitrates
          mem_write_d = d_mem_write;
          mem_read_d  = !d_mem_write;
          mem_addr_d  = d_mem_addr;
          mem_wdata_d = d_mem_wdata;
        end else if (i_mem_read) begin
          do_gnt_i    = 1'b1;
          state_d     = GNT_I;
          owner_d     = OWN_I;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          mem_addr_d  = i_mem_addr;
          mem_wdata_d = '0;
        end
      end
      GNT_I, GNT_D: begin
        if (mem_ready) begin
          state_d     = RELEASE;
          owner_d     = OWN_NONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  mem_arb_fairness_ctr #(
    .MAX_D_RUN(MAX_D_RUN)
  ) u_fair (
    .clk      (clk),
    .rst      (rst),
    .d_grant  (do_gnt_d),
    .i_grant  (do_gnt_i),
    .i_pending(i_mem_read),
    .force_i  (force_i)
  );

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign grant_i   = (owner_q == OWN_I);
  assign grant_d   = (owner_q == OWN_D);

  // owner is NONE outside GNT_x, so stray mem_ready is dropped
  assign i_mem_ready = grant_i & mem_ready;
  assign d_mem_ready = grant_d & mem_ready;
  assign i_mem_rdata = i_mem_ready ? mem_rdata : '0;
  assign d_mem_rdata = d_mem_ready ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, scoreboard
// of completions, and sequences for arbitration corners.
module tb_mem_port_arbiter;

  localparam int AW   = 28;
  localparam int LW   = 128;
  localparam int MAXR = 4;

  logic          clk;
  logic          rst;
  logic          i_mem_read;
  logic [AW-1:0] i_mem_addr;
  logic [LW-1:0] i_mem_rdata;
  logic          i_mem_ready;
  logic          d_mem_read;
  logic          d_mem_write;
  logic [AW-1:0] d_mem_addr;
  logic [LW-1:0] d_mem_wdata;
  logic [LW-1:0] d_mem_rdata;
  logic          d_mem_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_ready;
  logic          grant_i;
  logic          grant_d;

  mem_port_arbiter #(
    .ADDR_W   (AW),
    .LINE_W   (LW),
    .MAX_D_RUN(MAXR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_mem_read (i_mem_read),
    .i_mem_addr (i_mem_addr),
    .i_mem_rdata(i_mem_rdata),
    .i_mem_ready(i_mem_ready),
    .d_mem_read (d_mem_read),
    .d_mem_write(d_mem_write),
    .d_mem_addr (d_mem_addr),
    .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(d_mem_rdata),
    .d_mem_ready(d_mem_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .grant_i    (grant_i),
    .grant_d    (grant_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic          i_rd;
    logic          d_rd;
    logic          d_wr;
    logic [AW-1:0] i_addr;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] wdata;
    int            lat;
    logic [LW-1:0] rdata;
    logic          exp_d;
    logic          exp_rd;
    logic          exp_wr;
  } vec_t;

  typedef struct {
    logic          d;
    logic [LW-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[5];
  int   checks;
  int   failures;
  int   run_cnt;
  logic exp_d;

  task automatic chk(input string name, input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon();
    exp_t e;
    if (i_mem_ready || d_mem_ready) begin
      chk("two_ready", {127'd0, i_mem_ready & d_mem_ready}, '0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready: got i=%0b d=%0b expected none",
                 i_mem_ready, d_mem_ready);
      end else begin
        e = sb.pop_front();
        chk("sb_side", {127'd0, d_mem_ready}, {127'd0, e.d});
        chk("sb_rdata", e.d ? d_mem_rdata : i_mem_rdata, e.rdata);
        chk("sb_other_rdata", e.d ? i_mem_rdata : d_mem_rdata, '0);
      end
    end
  endtask

  task automatic half();
    @(negedge clk);
    mon();
  endtask

  task automatic adv();
    @(posedge clk);
    #2;
  endtask

  task automatic run_vec(input vec_t v);
    logic [AW-1:0] ea;
    ea = v.exp_d ? v.d_addr : v.i_addr;
    i_mem_read  = v.i_rd;
    d_mem_read  = v.d_rd;
    d_mem_write = v.d_wr;
    i_mem_addr  = v.i_addr;
    d_mem_addr  = v.d_addr;
    d_mem_wdata = v.wdata;
    sb.push_back('{v.exp_d, v.rdata});
    half();
    chk("v_pre_grant", {127'd0, grant_i | grant_d}, '0);
    adv();
    mem_rdata = v.rdata;
    mem_ready = (v.lat == 0);
    half();
    chk("v_grant_d", {127'd0, grant_d}, {127'd0, v.exp_d});
    chk("v_grant_i", {127'd0, grant_i}, {127'd0, !v.exp_d});
    chk("v_mem_read", {127'd0, mem_read}, {127'd0, v.exp_rd});
    chk("v_mem_write", {127'd0, mem_write}, {127'd0, v.exp_wr});
    chk("v_mem_addr", {100'd0, mem_addr}, {100'd0, ea});
    if (v.exp_wr) chk("v_mem_wdata", mem_wdata, v.wdata);
    for (int k = 1; k <= v.lat; k++) begin
      adv();
      mem_ready = (k == v.lat);
      half();
      chk("v_hold_addr", {100'd0, mem_addr}, {100'd0, ea});
    end
    chk("v_other_ready",
        {127'd0, v.exp_d ? i_mem_ready : d_mem_ready}, '0);
    adv();
    i_mem_read  = 1'b0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    mem_ready   = 1'b0;
    half();
    chk("v_rel_strobe", {127'd0, mem_read | mem_write}, '0);
    chk("v_rel_grant", {127'd0, grant_i | grant_d}, '0);
    adv();
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    run_cnt     = 0;
    rst         = 1'b1;
    i_mem_read  = 1'b0;
    i_mem_addr  = '0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    d_mem_addr  = '0;
    d_mem_wdata = '0;
    mem_rdata   = '0;
    mem_ready   = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 28'h0000010, 28'h0, '0, 3,
                128'hAAAA_0001_2222_0003_4444_0005_6666_0007,
                1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 28'h0, 28'h0000123, '0, 1,
                128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321,
                1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 28'h0, 28'h0000ABC,
                128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF, 2,
                128'h5555, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 28'h0, 28'h0000055,
                128'h0BAD_C0DE_0000_1111_2222_3333_4444_5555, 0,
                128'h7777, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 28'hFFFFFFF, 28'h0, '0, 0,
                128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000,
                1'b0, 1'b1, 1'b0};

    // reset state
    half();
    chk("rst_mem_read", {127'd0, mem_read}, '0);
    chk("rst_mem_write", {127'd0, mem_write}, '0);
    chk("rst_mem_addr", {100'd0, mem_addr}, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_grant", {126'd0, grant_i, grant_d}, '0);
    chk("rst_ready", {126'd0, i_mem_ready, d_mem_ready}, '0);
    chk("rst_rdata", i_mem_rdata | d_mem_rdata, '0);
    adv();
    rst = 1'b0;
    adv();

    for (int n = 0; n < 5; n++) run_vec(vecs[n]);

    // I read and D write raised together: D first, I at M+3
    i_mem_read  = 1'b1;
    i_mem_addr  = 28'h0000020;
    d_mem_write = 1'b1;
    d_mem_addr  = 28'h0000030;
    d_mem_wdata = 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10;
    sb.push_back('{1'b1, 128'h11});
    sb.push_back('{1'b0, 128'h22});
    half();
    adv();
    half();
    chk("sim_grant_d", {127'd0, grant_d}, 128'd1);
    chk("sim_mem_write", {127'd0, mem_write}, 128'd1);
    chk("sim_mem_wdata", mem_wdata,
        128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10);
    chk("sim_mem_addr", {100'd0, mem_addr}, 128'h30);
    adv();
    mem_ready = 1'b1;
    mem_rdata = 128'h11;
    half();
    chk("sim_i_wait", {127'd0, grant_i}, '0);
    adv();
    d_mem_write = 1'b0;
    mem_ready   = 1'b0;
    half();
    chk("sim_rel_grant", {126'd0, grant_i, grant_d}, '0);
    adv();
    half();
    chk("sim_idle_grant", {126'd0, grant_i, grant_d}, '0);
    adv();
    half();
    chk("sim_grant_i", {127'd0, grant_i}, 128'd1);
    chk("sim_i_read", {127'd0, mem_read}, 128'd1);
    chk("sim_i_addr", {100'd0, mem_addr}, 128'h20);
    adv();
    mem_ready = 1'b1;
    mem_rdata = 128'h22;
    half();
    adv();
    i_mem_read = 1'b0;
    mem_ready  = 1'b0;
    half();
    adv();

    // fairness: D and I both held high for five grants
    i_mem_read = 1'b1;
    i_mem_addr = 28'h0000040;
    d_mem_read = 1'b1;
    d_mem_addr = 28'h0000050;
    run_cnt    = 0;
    for (int g = 0; g < 5; g++) begin
      int w;
      w = 0;
      half();
      while (!(grant_i || grant_d) && w < 6) begin
        adv();
        half();
        w++;
      end
      chk("fair_seen", {127'd0, grant_i | grant_d}, 128'd1);
      exp_d = (run_cnt != MAXR);
      chk("fair_grant_d", {127'd0, grant_d}, {127'd0, exp_d});
      run_cnt = exp_d ? run_cnt + 1 : 0;
      sb.push_back('{exp_d, 128'(g + 100)});
      adv();
      mem_ready = 1'b1;
      mem_rdata = 128'(g + 100);
      half();
      adv();
      mem_ready = 1'b0;
      if (g == 4) begin
        i_mem_read = 1'b0;
        d_mem_read = 1'b0;
      end
    end
    half();
    adv();

    // address hold, then reset mid-transaction
    d_mem_write = 1'b1;
    d_mem_addr  = 28'h0000060;
    d_mem_wdata = 128'hC0FFEE;
    half();
    adv();
    half();
    chk("hold_grant_d", {127'd0, grant_d}, 128'd1);
    adv();
    d_mem_addr  = 28'h0000061;
    d_mem_wdata = 128'hBADBAD;
    half();
    chk("hold_addr", {100'd0, mem_addr}, 128'h60);
    chk("hold_wdata", mem_wdata, 128'hC0FFEE);
    chk("hold_write", {127'd0, mem_write}, 128'd1);
    adv();
    rst = 1'b1;
    #1;
    chk("rst_mid_write", {127'd0, mem_write}, '0);
    chk("rst_mid_grant", {127'd0, grant_d}, '0);
    d_mem_write = 1'b0;
    half();
    adv();
    rst       = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 128'h99;
    half();
    chk("stray_ready", {126'd0, i_mem_ready, d_mem_ready}, '0);
    chk("stray_rdata", i_mem_rdata | d_mem_rdata, '0);
    adv();
    mem_ready = 1'b0;
    half();
    adv();

    chk("sb_empty", 128'(sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
